// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the SRAM-like request/response memory model.
// No logic; constants and one combinational helper only.
// Not applicable (no handshake in a package).
package sram_resp_pkg;

  // Access size encodings carried on the size port.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // One outstanding request: write flag, cycles left to maturity, captured read data.
  typedef struct packed {
    logic        wr;
    logic [3:0]  timer;
    logic [31:0] data;
  } entry_t;

  // Stress LFSR: x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// Circular FIFO of outstanding requests, each with its own maturity countdown.
// Latency: push visible next cycle; head_ready once the head timer has reached 0.
// Backpressure: full blocks push; head stays until popped, younger timers saturate at 0.
module resp_queue
  import sram_resp_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     head_ready,
  output entry_t                   head_data,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [QDEPTH-1:0] vld_q, vld_d;
  entry_t        ent_q [QDEPTH];
  entry_t        ent_d [QDEPTH];
  logic          push_ok, pop_ok;

  assign full       = (count_q == FULL_CNT);
  assign head_ready = vld_q[head_q] && (ent_q[head_q].timer == 4'd0);
  assign head_data  = ent_q[head_q];
  assign count      = count_q;
  assign push_ok    = push && !full;
  assign pop_ok     = pop && head_ready;

  // Next state: age every live entry, retire the head, append at the tail.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    ent_d   = ent_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].timer != 4'd0)) begin
        ent_d[i].timer = ent_q[i].timer - 4'd1;
      end
    end
    if (pop_ok) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    // A push never lands on the head slot being popped: push needs !full.
    if (push_ok) begin
      vld_d[tail_q] = 1'b1;
      ent_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every outstanding entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder: word array behind a req/addr_ok, data_ok/rdata interface.
// Latency: data_ok LATENCY cycles after the accept edge, in order, at most one per cycle.
// Backpressure: addr_ok drops on stall, full queue or reset (SRAM_RESP_RAND_STALL_EN adds LFSR refusals).
module sram_like_responder
  import sram_resp_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]       mem_q [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic              mem_we;
  logic [31:0]       mem_wword;
  logic              q_full, q_head_ready;
  entry_t            q_head, push_entry;
  logic [$clog2(QDEPTH):0] q_count;
  logic              rand_block;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;

  // Reads always return the whole word, so size and the sub-word/aliased address bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0], q_count};

  assign idx     = addr[MEM_AW+1:2];
  assign rd_word = mem_q[idx];

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running stress LFSR.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign rand_block = (lfsr_q[1:0] == 2'b11);
`else
  assign rand_block = 1'b0;
`endif

  // No pop bypass: a full queue refuses even when its head retires this cycle.
  assign addr_ok = resetn & ~stall & ~q_full & ~rand_block;
  assign accept  = req & addr_ok;

  // Byte-lane merge for writes; wstrb=0 is a legal no-op write.
  always_comb begin
    mem_we    = accept & wr;
    mem_wword = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) mem_wword[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wword;
  end

  // Reads capture data at accept so later writes cannot leak into earlier reads.
  always_comb begin
    push_entry.wr    = wr;
    push_entry.timer = 4'(LATENCY - 1);
    push_entry.data  = wr ? 32'h0 : rd_word;
  end

  resp_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (q_head_ready),
    .full       (q_full),
    .head_ready (q_head_ready),
    .head_data  (q_head),
    .count      (q_count)
  );

  // Response stage: one registered pulse per matured head entry.
  always_comb begin
    data_ok_d = q_head_ready;
    rdata_d   = q_head_ready ? q_head.data : 32'h0;
  end

  // Response register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench for sram_like_responder: driver pushes expected responses, monitor checks them.
// A second instance with a long latency exposes the queue-full refusal pattern.
module tb_sram_like_responder;
  import sram_resp_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, req, wr, stall;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        addr_ok2, unused_data_ok2;
  logic [31:0] unused_rdata2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] sb_data[$];
  int          sb_cyc[$];

  logic [31:0] b_addr [8] = '{32'h10, 32'h20, 32'h4010, 32'h20, 32'h10, 32'h4020, 32'h10, 32'h20};
  logic [31:0] b_exp  [8] = '{32'hDEADAAEF, 32'h22222222, 32'hDEADAAEF, 32'h22222222,
                              32'hDEADAAEF, 32'h22222222, 32'hDEADAAEF, 32'h22222222};
  logic [7:0]  b_full = 8'b1000_1111;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_like_responder #(.MEM_AW(12), .LATENCY(LAT), .QDEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .stall(stall),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.MEM_AW(12), .LATENCY(6), .QDEPTH(4)) dut_long (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .stall(stall),
    .addr_ok(addr_ok2), .data_ok(unused_data_ok2), .rdata(unused_rdata2)
  );

  // Monitor: every data_ok must match the oldest expected response, data and cycle.
  always @(negedge clk) begin
    logic [31:0] ed;
    int          ec;
    if (data_ok === 1'b1) begin
      checks++;
      if (sb_data.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_ok: cyc=%0d rdata=%h, required no response", cyc, rdata);
      end else begin
        ed = sb_data.pop_front();
        ec = sb_cyc.pop_front();
        if (rdata !== ed || cyc != ec) begin
          errors++;
          $display("FAIL response: got rdata=%h at cyc %0d, required %h at cyc %0d", rdata, cyc, ed, ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] exp);
    sb_data.push_back(exp);
    sb_cyc.push_back(cyc + 1 + LAT);
  endtask

  // Present one request until accepted (bounded), recording the expected response.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp);
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = SIZE_WORD;
      #1;
      if (addr_ok === 1'b1) begin
        expect_rsp(exp);
        done = 1;
      end
      @(negedge clk);
    end
    req = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: addr=%h not accepted within 40 cycles, required accept", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = SIZE_WORD;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; stall = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_data_ok", 32'(data_ok), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    #1 check("reset_addr_ok", 32'(addr_ok), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("post_reset_addr_ok", 32'(addr_ok), 32'h1);
    @(negedge clk);

    // Full write then read back
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    idle(4);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF);
    idle(4);

    // Partial write on byte lane 1
    issue(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'h0);
    idle(4);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF);
    idle(4);

    // Read followed immediately by a write to the same word keeps program order
    issue(1'b1, 32'h20, 4'hF, 32'h11111111, 32'h0);
    idle(4);
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111);
    issue(1'b1, 32'h20, 4'hF, 32'h22222222, 32'h0);
    idle(4);
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h22222222);
    idle(10);

    // Sustained back-to-back reads (with aliasing); the long-latency copy fills and refuses
    for (int k = 0; k < 8; k++) begin
      req = 1'b1; wr = 1'b0; addr = b_addr[k]; wstrb = 4'h0;
      #1;
      check("burst_addr_ok", 32'(addr_ok), 32'h1);
      check("full_addr_ok", 32'(addr_ok2), 32'(b_full[k]));
      if (addr_ok === 1'b1) expect_rsp(b_exp[k]);
      @(negedge clk);
    end
    req = 1'b0;
    idle(6);

    // Stall holds off accepts; release accepts at once
    stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_addr_ok", 32'(addr_ok), 32'h0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 check("unstall_addr_ok", 32'(addr_ok), 32'h1);
    if (addr_ok === 1'b1) expect_rsp(32'hDEADAAEF);
    @(negedge clk);
    req = 1'b0;
    idle(5);

    // Reset with reads outstanding drops them; array survives
    issue(1'b1, 32'h30, 4'hF, 32'h30303030, 32'h0);
    idle(4);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF);
    resetn = 1'b0;
    #1 check("midreset_addr_ok", 32'(addr_ok), 32'h0);
    @(negedge clk);
    sb_data.delete();
    sb_cyc.delete();
    check("midreset_count", 32'(dut.u_queue.count_q), 32'h0);
    check("midreset_data_ok", 32'(data_ok), 32'h0);
    resetn = 1'b1;
    idle(8);
    issue(1'b0, 32'h30, 4'h0, 32'h0, 32'h30303030);
    idle(6);

    check("scoreboard_drained", 32'(sb_data.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
